controle_divisor: RTL and testbench

Sequencing and configuration controller for the board's clock-divider resource. It holds a programmable divide value, and starts and stops the divider on command. It runs it free or for a fixed number of periods, and emits a one-cycle `tick` enable plus a square-wave `novo_clock` derived from the 50 MHz board clock. It sits between user logic (buttons/FSMs) and anything that needs a slow timebase, such as displays and counters.

---
 rtl/controle_divisor_if.sv | 28 ++
 rtl/controle_divisor.sv | 109 ++++++++++
 tb/tb_controle_divisor.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/controle_divisor_if.sv
// Configuration handshake bundle for controle_divisor: valid/ready with divide value and period count.
// The slave raises err for one cycle when an accepted request carries an illegal divide value.
interface controle_divisor_if #(
  parameter int WIDTH = 26,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_count;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    output cfg_count,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    input  cfg_count,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/controle_divisor.sv
// Clock-divider controller: programmable divide value, free or N-period runs, tick pulse and square wave.
// All outputs registered except cfg_ready; config is back-pressured (cfg_ready=0) while a run is active.
module controle_divisor #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50000000,
  parameter int CNT_W       = 8
) (
  input  logic                  clock_50,
  input  logic                  reset,
  controle_divisor_if.slave     cfg,
  input  logic                  start,
  input  logic                  stop,
  output logic                  tick,
  output logic                  novo_clock,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      ticks_left
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] div_r, div_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [CNT_W-1:0] ticks_n;
  logic             tick_n, done_n, novo_n, err_n;
  logic             cfg_acc, cfg_legal;

  assign cfg.cfg_ready = (state != RUN);
  assign cfg_acc       = cfg.cfg_valid & cfg.cfg_ready;
  assign cfg_legal     = (cfg.cfg_div >= WIDTH'(2));

  always_comb begin
    div_n   = div_r;
    cnt_n   = cnt_r;
    state_n = state;
    q_n     = q;
    ticks_n = ticks_left;
    tick_n  = 1'b0;
    done_n  = done;
    err_n   = cfg_acc & ~cfg_legal;

    // A legal config accepted on the start edge is already visible to the new run.
    if (cfg_acc && cfg_legal) begin
      div_n = cfg.cfg_div;
      cnt_n = cfg.cfg_count;
    end

    case (state)
      RUN: begin
        if (stop) begin
          state_n = IDLE;
          q_n     = '0;
          ticks_n = '0;
        end else if (q == div_r - WIDTH'(1)) begin
          q_n    = '0;
          tick_n = 1'b1;
          if (ticks_left != '0) begin
            ticks_n = ticks_left - CNT_W'(1);
            if (ticks_left == CNT_W'(1)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end else begin
          q_n = q + WIDTH'(1);
        end
      end
      default: begin
        if (start && !stop) begin
          state_n = RUN;
          q_n     = '0;
          ticks_n = cnt_n;
          done_n  = 1'b0;
        end
      end
    endcase

    novo_n = (state_n == RUN) && (q_n >= (div_n >> 1));
  end

  always_ff @(posedge clock_50) begin
    if (reset) begin
      state      <= IDLE;
      q          <= '0;
      div_r      <= WIDTH'(DEFAULT_DIV);
      cnt_r      <= '0;
      ticks_left <= '0;
      tick       <= 1'b0;
      novo_clock <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state      <= state_n;
      q          <= q_n;
      div_r      <= div_n;
      cnt_r      <= cnt_n;
      ticks_left <= ticks_n;
      tick       <= tick_n;
      novo_clock <= novo_n;
      busy       <= (state_n == RUN);
      done       <= done_n;
      cfg.cfg_err <= err_n;
    end
  end

endmodule

// File: tb/tb_controle_divisor.sv
// Directed bench for controle_divisor with DEFAULT_DIV overridden to 10.
module tb_controle_divisor;
  localparam int WIDTH = 26;
  localparam int CNT_W = 8;

  logic             clock_50 = 1'b0;
  logic             reset    = 1'b1;
  logic             start    = 1'b0;
  logic             stop     = 1'b0;
  logic             tick, novo_clock, busy, done;
  logic [CNT_W-1:0] ticks_left;

  int vectors     = 0;
  int miscompares = 0;

  controle_divisor_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) cfg_bus ();

  controle_divisor #(.WIDTH(WIDTH), .DEFAULT_DIV(10), .CNT_W(CNT_W)) dut (
    .clock_50   (clock_50),
    .reset      (reset),
    .cfg        (cfg_bus),
    .start      (start),
    .stop       (stop),
    .tick       (tick),
    .novo_clock (novo_clock),
    .busy       (busy),
    .done       (done),
    .ticks_left (ticks_left)
  );

  always #5 clock_50 = ~clock_50;

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock_50);
    #1;
  endtask

  task automatic set_cfg(input bit vld, input int div, input int cnt);
    cfg_bus.cfg_valid = vld;
    cfg_bus.cfg_div   = WIDTH'(div);
    cfg_bus.cfg_count = CNT_W'(cnt);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".tick"},  int'(tick),       0);
    chk({tag, ".novo"},  int'(novo_clock), 0);
    chk({tag, ".busy"},  int'(busy),       0);
    chk({tag, ".done"},  int'(done),       0);
    chk({tag, ".err"},   int'(cfg_bus.cfg_err), 0);
    chk({tag, ".left"},  int'(ticks_left), 0);
    chk({tag, ".rdy"},   int'(cfg_bus.cfg_ready), 1);
  endtask

  // Called right after the start edge k; checks cycles following edges k+1..k+ncyc.
  task automatic run_check(input string tag, input int div, input int cnt, input int ncyc);
    for (int j = 1; j <= ncyc; j++) begin
      int ph, per;
      bit fin;
      step();
      ph  = j % div;
      per = j / div;
      fin = (cnt != 0) && (j >= cnt * div);
      chk({tag, ".tick"}, int'(tick), ((ph == 0) && (cnt == 0 || per <= cnt)) ? 1 : 0);
      chk({tag, ".busy"}, int'(busy), fin ? 0 : 1);
      chk({tag, ".done"}, int'(done), fin ? 1 : 0);
      chk({tag, ".left"}, int'(ticks_left), (cnt == 0 || fin) ? 0 : cnt - per);
      chk({tag, ".novo"}, int'(novo_clock), (!fin && ph >= div / 2) ? 1 : 0);
      chk({tag, ".rdy"},  int'(cfg_bus.cfg_ready), fin ? 1 : 0);
    end
  endtask

  initial begin
    set_cfg(0, 0, 0);
    step();
    step();
    chk_quiet("reset");
    reset = 1'b0;

    // Free run, divide by 4.
    set_cfg(1, 4, 0);
    step();
    set_cfg(0, 0, 0);
    chk("cfg4.err", int'(cfg_bus.cfg_err), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run4.busy0", int'(busy), 1);
    chk("run4.novo0", int'(novo_clock), 0);
    run_check("run4", 4, 0, 12);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_quiet("stop4");

    // Finite run of 3 periods, divide by 5.
    set_cfg(1, 5, 3);
    step();
    set_cfg(0, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("fin5.left0", int'(ticks_left), 3);
    run_check("fin5", 5, 3, 20);

    // Illegal divide in DONE: error pulse, old values kept.
    set_cfg(1, 1, 7);
    step();
    set_cfg(0, 0, 0);
    chk("ill.err", int'(cfg_bus.cfg_err), 1);
    chk("ill.done", int'(done), 1);
    step();
    chk("ill.err_clr", int'(cfg_bus.cfg_err), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("old5.done_clr", int'(done), 0);
    run_check("old5", 5, 3, 17);

    // Stop on the terminal-count edge suppresses the tick.
    set_cfg(1, 4, 0);
    start = 1'b1;
    step();
    set_cfg(0, 0, 0);
    start = 1'b0;
    chk("s4.done_clr", int'(done), 0);
    step(); step(); step();
    chk("s4.novo_q3", int'(novo_clock), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk_quiet("stopq3");
    step();
    chk("stopq3.tick_after", int'(tick), 0);
    start = 1'b1;
    step();
    start = 1'b0;
    run_check("restart4", 4, 0, 8);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // start+stop together: stay idle.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    chk_quiet("startstop");

    // start with a legal config on the same edge uses it.
    set_cfg(1, 6, 0);
    start = 1'b1;
    step();
    set_cfg(0, 0, 0);
    start = 1'b0;
    run_check("same6", 6, 0, 13);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Reset mid finite run restores DEFAULT_DIV.
    set_cfg(1, 8, 2);
    start = 1'b1;
    step();
    set_cfg(0, 0, 0);
    start = 1'b0;
    step(); step(); step(); step(); step();
    chk("r8.busy", int'(busy), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_quiet("midreset");
    start = 1'b1;
    step();
    start = 1'b0;
    run_check("dflt10", 10, 0, 25);
    stop = 1'b1;
    step();
    stop = 1'b0;

    // Illegal config on the start edge: run proceeds with the old divide.
    set_cfg(1, 0, 4);
    start = 1'b1;
    step();
    set_cfg(0, 0, 0);
    start = 1'b0;
    chk("illstart.err", int'(cfg_bus.cfg_err), 1);
    chk("illstart.busy", int'(busy), 1);
    run_check("illstart", 10, 0, 12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
